// File: rtl/ppu_wfifo_pkg.sv
// Shared types and constants for the PPU posting write buffer.
// The optional high-water-mark interrupt is enabled by defining PPU_WFIFO_HWM_IRQ_EN.
package ppu_wfifo_pkg;

    // One queued CPU write: PPU word address plus write data.
    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } wfifo_entry_t;

    localparam int ENTRY_W = $bits(wfifo_entry_t);

    // IDLE holds writes back during active video; DRAIN empties the queue during vblank.
    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wfifo_state_t;

    // Word address that acknowledges the interrupt instead of being queued.
    localparam logic [11:0] CTRL_ADDR_DEFAULT = 12'hFFF;

endpackage

// File: rtl/ppu_wfifo_mem.sv
// Storage for the PPU write buffer: DEPTH entries, one synchronous write port
// and one asynchronous read port so the queue head is always visible.
module ppu_wfifo_mem #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 44,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store an entry on the clock edge it is pushed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ppu_write_fifo.sv
// Posting write buffer between the HPS lightweight Avalon-MM slave and the PPU.
// CPU writes are queued during active video and replayed into the PPU only while
// vblank is high, so memory updates never tear mid-frame. Also owns the vblank
// interrupt, acknowledged by a write to CTRL_ADDR.
// Optional feature macro: PPU_WFIFO_HWM_IRQ_EN (irq also raised when occupancy
// reaches HWM).
module ppu_write_fifo
    import ppu_wfifo_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [11:0] CTRL_ADDR = CTRL_ADDR_DEFAULT,
    parameter int          HWM       = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    av_chipselect,
    input  logic                    av_write,
    input  logic [11:0]             av_address,
    input  logic [31:0]             av_writedata,
    output logic                    av_waitrequest,
    input  logic                    vblank,
    output logic                    ppu_chipselect,
    output logic                    ppu_write,
    output logic [11:0]             ppu_address,
    output logic [31:0]             ppu_write_data,
    output logic                    irq,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    wfifo_state_t       state;
    wfifo_state_t       state_next;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    wfifo_entry_t       wr_entry;
    wfifo_entry_t       head_entry;
    logic [ENTRY_W-1:0] head_word;
    logic               push;
    logic               pop;
    logic               ctrl_wr;
    logic               vblank_q;
    logic               vblank_rise;
    logic               hwm_set;

    // The stall depends only on the registered count, so a pop in the same
    // cycle does not let a push through until the following cycle.
    assign av_waitrequest = (count == DEPTH_CNT);

    assign ctrl_wr = av_chipselect && av_write && (av_address == CTRL_ADDR);
    assign push    = av_chipselect && av_write && !av_waitrequest && (av_address != CTRL_ADDR);

    assign wr_entry.addr = av_address;
    assign wr_entry.data = av_writedata;
    assign head_entry    = wfifo_entry_t'(head_word);

    ppu_wfifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head_word)
    );

    // Pointers wrap naturally because DEPTH is a power of two; full versus
    // empty is told apart by count, never by comparing the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register for the drain controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Drain only while vblank is high; a falling vblank stops new pops at once.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (vblank && (count != '0)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                pop = vblank && (count != '0);
                if (!vblank) begin
                    state_next = IDLE;
                end else if (pop && (count == ONE_CNT)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register the popped head onto the PPU bus; address/data hold between pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            ppu_chipselect <= 1'b0;
            ppu_write      <= 1'b0;
            ppu_address    <= '0;
            ppu_write_data <= '0;
        end else begin
            ppu_chipselect <= pop;
            ppu_write      <= pop;
            if (pop) begin
                ppu_address    <= head_entry.addr;
                ppu_write_data <= head_entry.data;
            end
        end
    end

    assign vblank_rise = vblank && !vblank_q;

`ifdef PPU_WFIFO_HWM_IRQ_EN
    logic hwm_armed;
    logic hwm_level;

    assign hwm_level = (count >= CNT_W'(HWM));
    assign hwm_set   = hwm_armed && hwm_level;

    // One interrupt per crossing: disarm on firing, re-arm once occupancy drops below HWM.
    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_armed <= 1'b1;
        end else if (!hwm_level) begin
            hwm_armed <= 1'b1;
        end else if (hwm_set) begin
            hwm_armed <= 1'b0;
        end
    end
`else
    // HWM is accepted as a parameter but has no effect in this build.
    assign hwm_set = 1'b0 & (count >= CNT_W'(HWM));
`endif

    // Interrupt: set on a vblank rising edge (or HWM), cleared by a CTRL write;
    // a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            vblank_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            vblank_q <= vblank;
            if (vblank_rise || hwm_set) begin
                irq <= 1'b1;
            end else if (ctrl_wr) begin
                irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ppu_write_fifo.sv
// Scoreboard bench for ppu_write_fifo: accepted writes are pushed as expected
// entries, and a monitor compares every PPU write against the queue head.
// High-water-mark checks follow PPU_WFIFO_HWM_IRQ_EN.
module tb_ppu_write_fifo;
    import ppu_wfifo_pkg::*;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;
    localparam logic [11:0] CTRL = 12'hFFF;
`ifdef PPU_WFIFO_HWM_IRQ_EN
    localparam bit HWM_EN = 1'b1;
`else
    localparam bit HWM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             av_chipselect = 1'b0;
    logic             av_write = 1'b0;
    logic [11:0]      av_address = '0;
    logic [31:0]      av_writedata = '0;
    logic             av_waitrequest;
    logic             vblank = 1'b0;
    logic             ppu_chipselect;
    logic             ppu_write;
    logic [11:0]      ppu_address;
    logic [31:0]      ppu_write_data;
    logic             irq;
    logic [CNT_W-1:0] count;

    int errors = 0;
    int checks = 0;
    int emitted = 0;
    int cycle = 0;
    int last_accept_cycle = 0;
    wfifo_entry_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    ppu_write_fifo #(
        .DEPTH     (DEPTH),
        .CTRL_ADDR (CTRL),
        .HWM       (48)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .av_chipselect  (av_chipselect),
        .av_write       (av_write),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_waitrequest (av_waitrequest),
        .vblank         (vblank),
        .ppu_chipselect (ppu_chipselect),
        .ppu_write      (ppu_write),
        .ppu_address    (ppu_address),
        .ppu_write_data (ppu_write_data),
        .irq            (irq),
        .count          (count)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every PPU write must match the oldest outstanding accepted write.
    always @(negedge clk) begin : monitor
        wfifo_entry_t e;
        if (!reset && ppu_write) begin
            emitted++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_ppu_write: got addr 0x%0h data 0x%0h, expected no write",
                         ppu_address, ppu_write_data);
            end else begin
                e = exp_q.pop_front();
                checkOutput("drain_entry", {20'h0, ppu_address, ppu_write_data}, {20'h0, e.addr, e.data});
                checkOutput("drain_chipselect", {63'h0, ppu_chipselect}, 64'h1);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d);
        bit accepted;
        wfifo_entry_t e;
        accepted = 1'b0;
        av_chipselect = 1'b1;
        av_write      = 1'b1;
        av_address    = a;
        av_writedata  = d;
        for (int i = 0; i < 300 && !accepted; i++) begin
            @(negedge clk);
            accepted = (a == CTRL) || !av_waitrequest;
            @(posedge clk);
            #1;
        end
        av_chipselect = 1'b0;
        av_write      = 1'b0;
        last_accept_cycle = cycle;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL write_accept_timeout: got stalled addr 0x%0h, expected acceptance", a);
        end else if (a != CTRL) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (count == '0) && !ppu_write;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got count %0d, expected 0", count);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int e1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset_ppu_write", ppu_write, 0);
        checkOutput("reset_ppu_chipselect", ppu_chipselect, 0);
        checkOutput("reset_ppu_address", ppu_address, 0);
        checkOutput("reset_ppu_write_data", ppu_write_data, 0);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_waitrequest", av_waitrequest, 0);
        checkOutput("reset_irq", irq, 0);
        step(1);

        // Three writes held during active video, then drained with 2-cycle latency
        $display("[TB] basic queue and drain");
        applyStimulus(12'h010, 32'hAAAA0001);
        applyStimulus(12'h011, 32'hAAAA0002);
        applyStimulus(12'h200, 32'h00FF00FF);
        @(negedge clk);
        checkOutput("basic_count3", count, 3);
        checkOutput("basic_no_write_active", ppu_write, 0);
        @(posedge clk);
        #1;
        emitted = 0;
        vblank = 1'b1;
        @(negedge clk);
        checkOutput("latency_before_edge1", ppu_write, 0);
        @(negedge clk);
        checkOutput("latency_after_edge1", ppu_write, 0);
        @(negedge clk);
        checkOutput("latency_after_edge2", ppu_write, 1);
        @(negedge clk);
        checkOutput("burst_second", ppu_write, 1);
        @(negedge clk);
        checkOutput("burst_third", ppu_write, 1);
        checkOutput("basic_count_end", count, 0);
        @(negedge clk);
        checkOutput("burst_end", ppu_write, 0);
        checkOutput("basic_emitted", emitted, 3);
        @(posedge clk);
        #1;
        vblank = 1'b0;
        step(2);

        // Fill to DEPTH, stall the 65th write until one pop has happened
        $display("[TB] full and stall");
        emitted = 0;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(12'h100 + 12'(i), 32'hF1110000 + 32'(i));
        end
        @(negedge clk);
        checkOutput("full_count", count, 64);
        checkOutput("full_waitrequest", av_waitrequest, 1);
        @(posedge clk);
        #1;
        e1 = cycle;
        vblank = 1'b1;
        applyStimulus(12'h3AB, 32'h65656565);
        checkOutput("stall_accept_delay", last_accept_cycle - e1, 3);
        waitDrain(200);
        vblank = 1'b0;
        checkOutput("full_emitted", emitted, 65);
        checkOutput("full_scoreboard_empty", exp_q.size(), 0);
        step(2);

        // Short vblank: partial drain, nothing after the fall, remainder next vblank
        $display("[TB] drain cutoff");
        emitted = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(12'h040, 32'hB0000000 + 32'(i));
        end
        vblank = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vblank = 1'b0;
        step(5);
        checkOutput("cutoff_emitted_3_or_4", (emitted >= 3 && emitted <= 4), 1);
        checkOutput("cutoff_count", count, 64'(10 - emitted));
        e1 = emitted;
        step(10);
        checkOutput("cutoff_no_write_after_fall", emitted, e1);
        vblank = 1'b1;
        waitDrain(100);
        vblank = 1'b0;
        checkOutput("cutoff_total_emitted", emitted, 10);
        checkOutput("cutoff_scoreboard_empty", exp_q.size(), 0);
        step(2);

        // Interrupt set/ack behaviour
        $display("[TB] irq");
        applyStimulus(CTRL, 32'h0);
        @(negedge clk);
        checkOutput("irq_ack_initial", irq, 0);
        @(posedge clk);
        #1;
        vblank = 1'b1;
        step(1);
        @(negedge clk);
        checkOutput("irq_set_on_vblank_rise", irq, 1);
        @(posedge clk);
        #1;
        vblank = 1'b0;
        step(2);
        applyStimulus(12'h021, 32'h12345678);
        applyStimulus(12'h022, 32'h9ABCDEF0);
        applyStimulus(CTRL, 32'h1);
        @(negedge clk);
        checkOutput("irq_cleared_by_ctrl", irq, 0);
        checkOutput("ctrl_count_unchanged", count, 2);
        @(posedge clk);
        #1;
        vblank = 1'b1;
        applyStimulus(CTRL, 32'h2);
        @(negedge clk);
        checkOutput("irq_set_wins_over_clear", irq, 1);
        waitDrain(50);
        vblank = 1'b0;
        step(2);
        applyStimulus(CTRL, 32'h3);
        @(negedge clk);
        checkOutput("irq_ack_after_drain", irq, 0);
        step(1);

        // Pointer wrap: 150 entries across three vblanks
        $display("[TB] wrap");
        emitted = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 50; i++) begin
                applyStimulus(12'(b * 50 + i), 32'hC0DE0000 + 32'(b * 50 + i));
            end
            @(negedge clk);
            checkOutput("wrap_batch_count", count, 50);
            @(posedge clk);
            #1;
            vblank = 1'b1;
            waitDrain(100);
            vblank = 1'b0;
            step(2);
        end
        checkOutput("wrap_emitted", emitted, 150);
        checkOutput("wrap_scoreboard_empty", exp_q.size(), 0);

        // High-water mark interrupt (must stay silent when the feature is off)
        $display("[TB] high-water mark");
        applyStimulus(CTRL, 32'h4);
        for (int i = 0; i < 47; i++) begin
            applyStimulus(12'h300 + 12'(i), 32'hD0000000 + 32'(i));
        end
        step(2);
        @(negedge clk);
        checkOutput("hwm_irq_at_47", irq, 0);
        checkOutput("hwm_count_47", count, 47);
        @(posedge clk);
        #1;
        applyStimulus(12'h32F, 32'hD000002F);
        step(1);
        @(negedge clk);
        checkOutput("hwm_irq_at_48", irq, HWM_EN);
        @(posedge clk);
        #1;
        applyStimulus(CTRL, 32'h5);
        applyStimulus(12'h330, 32'hD0000030);
        step(2);
        @(negedge clk);
        checkOutput("hwm_irq_after_ack_49", irq, 0);
        checkOutput("hwm_count_49", count, 49);
        @(posedge clk);
        #1;
        vblank = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        vblank = 1'b0;
        step(2);
        @(negedge clk);
        checkOutput("hwm_drained_to_10", count, 10);
        @(posedge clk);
        #1;
        applyStimulus(CTRL, 32'h6);
        for (int i = 0; i < 37; i++) begin
            applyStimulus(12'h340 + 12'(i), 32'hE0000000 + 32'(i));
        end
        step(2);
        @(negedge clk);
        checkOutput("hwm_refill_irq_at_47", irq, 0);
        @(posedge clk);
        #1;
        applyStimulus(12'h365, 32'hE0000025);
        step(1);
        @(negedge clk);
        checkOutput("hwm_refill_irq_at_48", irq, HWM_EN);
        @(posedge clk);
        #1;
        vblank = 1'b1;
        waitDrain(100);
        vblank = 1'b0;
        checkOutput("hwm_scoreboard_empty", exp_q.size(), 0);
        step(2);

        // Reset in the middle of a drain discards the queue
        $display("[TB] reset mid-drain");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(12'h0A0 + 12'(i), 32'h77000000 + 32'(i));
        end
        vblank = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b1;
        vblank = 1'b0;
        step(1);
        @(negedge clk);
        checkOutput("midreset_ppu_write", ppu_write, 0);
        checkOutput("midreset_count", count, 0);
        checkOutput("midreset_irq", irq, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(10);
        @(negedge clk);
        checkOutput("postreset_count", count, 0);
        checkOutput("postreset_ppu_write", ppu_write, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
